// File: rtl/rgb_to_ycbcr_if.sv
// AXI4-Stream video bus carrying one pixel per beat with SOF on tuser and EOL on tlast.
interface axi4_stream_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DEST_WIDTH = 4
) ();
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tuser;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;

  modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest, output tready);
endinterface

// File: rtl/rgb_to_ycbcr.sv
// Three-stage back-pressurable RGB to full-range BT.601 YCbCr converter (multiply, sum, clamp).
// Sidebands ride along with each beat; bubbles collapse through the per-stage ready chain.
module rgb_to_ycbcr #(
  parameter int unsigned PX_WIDTH    = 10,
  parameter int unsigned FRACT_WIDTH = 10,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned DEST_WIDTH  = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  video_i,
  axi4_stream_if.master video_o
);

  localparam int unsigned TDATA_WIDTH = ((PX_WIDTH * 3 + 7) / 8) * 8;
  localparam int unsigned KEEP_WIDTH  = TDATA_WIDTH / 8;
  localparam int unsigned PROD_W      = PX_WIDTH + FRACT_WIDTH + 2;
  localparam int unsigned SUM_W       = PX_WIDTH + FRACT_WIDTH + 4;

  // Coefficients given in millionths, rounded half away from zero to FRACT_WIDTH bits.
  function automatic int coef(input longint k_ppm);
    longint num;
    num = k_ppm * (longint'(1) << FRACT_WIDTH);
    if (num >= 0) return int'((num + 500000) / 1000000);
    return -int'((-num + 500000) / 1000000);
  endfunction

  localparam logic signed [PROD_W-1:0] K_YR = PROD_W'(coef(299000));
  localparam logic signed [PROD_W-1:0] K_YG = PROD_W'(coef(587000));
  localparam logic signed [PROD_W-1:0] K_YB = PROD_W'(coef(114000));
  localparam logic signed [PROD_W-1:0] K_BR = PROD_W'(coef(-168736));
  localparam logic signed [PROD_W-1:0] K_BG = PROD_W'(coef(-331264));
  localparam logic signed [PROD_W-1:0] K_BB = PROD_W'(coef(500000));
  localparam logic signed [PROD_W-1:0] K_RR = PROD_W'(coef(500000));
  localparam logic signed [PROD_W-1:0] K_RG = PROD_W'(coef(-418688));
  localparam logic signed [PROD_W-1:0] K_RB = PROD_W'(coef(-81312));

  localparam logic signed [SUM_W-1:0] C_RND   = SUM_W'(longint'(1) << (FRACT_WIDTH - 1));
  localparam logic signed [SUM_W-1:0] C_OFS   = SUM_W'((longint'(1) << (PX_WIDTH - 1 + FRACT_WIDTH))
                                                       + (longint'(1) << (FRACT_WIDTH - 1)));
  localparam logic signed [SUM_W-1:0] C_PXMAX = SUM_W'((longint'(1) << PX_WIDTH) - 1);

  typedef struct packed {
    logic                  tlast;
    logic                  tuser;
    logic [KEEP_WIDTH-1:0] tstrb;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
  } side_t;

  function automatic logic signed [PROD_W-1:0] mul(input logic [PX_WIDTH-1:0] c,
                                                   input logic signed [PROD_W-1:0] k);
    logic signed [PROD_W-1:0] cx;
    cx = $signed(PROD_W'(c));
    return cx * k;
  endfunction

  function automatic logic signed [SUM_W-1:0] sum3(input logic signed [PROD_W-1:0] a,
                                                   input logic signed [PROD_W-1:0] b,
                                                   input logic signed [PROD_W-1:0] c,
                                                   input logic signed [SUM_W-1:0]  ofs);
    return SUM_W'(a) + SUM_W'(b) + SUM_W'(c) + ofs;
  endfunction

  function automatic logic [PX_WIDTH-1:0] clamp(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] q;
    q = s >>> FRACT_WIDTH;
    if (q < 0)       return '0;
    if (q > C_PXMAX) return '1;
    return q[PX_WIDTH-1:0];
  endfunction

  logic                     w_rdy1, w_rdy2, w_rdy3;
  logic [PX_WIDTH-1:0]      w_r, w_g, w_b;
  side_t                    w_sb_in;

  logic                     r_v1, r_v2, r_v3;
  logic signed [PROD_W-1:0] r_p [9];
  logic signed [SUM_W-1:0]  r_sy, r_scb, r_scr;
  side_t                    r_sb1, r_sb2, r_sb3;
  logic [TDATA_WIDTH-1:0]   r_tdata;

  // A stage may load when it is empty or its successor is loading.
  assign w_rdy3 = video_o.tready || !r_v3;
  assign w_rdy2 = w_rdy3 || !r_v2;
  assign w_rdy1 = w_rdy2 || !r_v1;
  assign video_i.tready = w_rdy1 && !rst_i;

  assign w_r = video_i.tdata[3*PX_WIDTH-1 -: PX_WIDTH];
  assign w_b = video_i.tdata[2*PX_WIDTH-1 -: PX_WIDTH];
  assign w_g = video_i.tdata[PX_WIDTH-1 -: PX_WIDTH];
  assign w_sb_in = '{tlast: video_i.tlast, tuser: video_i.tuser, tstrb: video_i.tstrb,
                     tkeep: video_i.tkeep, tid: video_i.tid, tdest: video_i.tdest};

  if (TDATA_WIDTH > 3 * PX_WIDTH) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = ^video_i.tdata[TDATA_WIDTH-1:3*PX_WIDTH];
  end

  // S1: nine products
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v1  <= 1'b0;
      r_sb1 <= '0;
      for (int i = 0; i < 9; i++) r_p[i] <= '0;
    end else if (w_rdy1) begin
      r_v1   <= video_i.tvalid;
      r_sb1  <= w_sb_in;
      r_p[0] <= mul(w_r, K_YR);
      r_p[1] <= mul(w_g, K_YG);
      r_p[2] <= mul(w_b, K_YB);
      r_p[3] <= mul(w_r, K_BR);
      r_p[4] <= mul(w_g, K_BG);
      r_p[5] <= mul(w_b, K_BB);
      r_p[6] <= mul(w_r, K_RR);
      r_p[7] <= mul(w_g, K_RG);
      r_p[8] <= mul(w_b, K_RB);
    end
  end

  // S2: rounded sums, chroma offset to mid-scale
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v2  <= 1'b0;
      r_sb2 <= '0;
      r_sy  <= '0;
      r_scb <= '0;
      r_scr <= '0;
    end else if (w_rdy2) begin
      r_v2  <= r_v1;
      r_sb2 <= r_sb1;
      r_sy  <= sum3(r_p[0], r_p[1], r_p[2], C_RND);
      r_scb <= sum3(r_p[3], r_p[4], r_p[5], C_OFS);
      r_scr <= sum3(r_p[6], r_p[7], r_p[8], C_OFS);
    end
  end

  // S3: scale, clamp and drive the output bus
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v3    <= 1'b0;
      r_sb3   <= '0;
      r_tdata <= '0;
    end else if (w_rdy3) begin
      r_v3    <= r_v2;
      r_sb3   <= r_sb2;
      r_tdata <= TDATA_WIDTH'({clamp(r_sy), clamp(r_scb), clamp(r_scr)});
    end
  end

  assign video_o.tvalid = r_v3;
  assign video_o.tdata  = r_tdata;
  assign video_o.tlast  = r_sb3.tlast;
  assign video_o.tuser  = r_sb3.tuser;
  assign video_o.tstrb  = r_sb3.tstrb;
  assign video_o.tkeep  = r_sb3.tkeep;
  assign video_o.tid    = r_sb3.tid;
  assign video_o.tdest  = r_sb3.tdest;

endmodule
